// File: rtl/video_timing_pkg.sv
// Shared timing types and 720p defaults for the video timing generator.
package video_timing_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_timing_t;

    localparam axis_timing_t H_720P = '{active: 1280, fp: 110, sync: 40, bp: 220};
    localparam axis_timing_t V_720P = '{active: 720,  fp: 5,   sync: 5,  bp: 20};

    function automatic int axis_total(axis_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One axis of the raster: wrapping position counter plus active/sync decode of the current count.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = 8,
    parameter int FP     = 2,
    parameter int SYNC   = 3,
    parameter int BP     = 2,
    parameter bit POL    = 1'b1,
    localparam int TOTAL = axis_total('{active: ACTIVE, fp: FP, sync: SYNC, bp: BP}),
    localparam int W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_param
        $error("timing_axis_counter: every timing parameter must be >= 1");
    end

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] cnt_q, cnt_d;
    logic         at_last;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign wrap   = inc & at_last;
    assign active = (cnt_q < ACT_END);
    // sync is already polarity-adjusted so the top only has to register it
    assign sync   = ((cnt_q >= SYNC_START) && (cnt_q < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal/vertical counters with registered sync, DE and position outputs.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_720P.active,
    parameter int H_FP     = H_720P.fp,
    parameter int H_SYNC   = H_720P.sync,
    parameter int H_BP     = H_720P.bp,
    parameter int V_ACTIVE = V_720P.active,
    parameter int V_FP     = V_720P.fp,
    parameter int V_SYNC   = V_720P.sync,
    parameter int V_BP     = V_720P.bp,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    localparam int H_TOTAL = axis_total('{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP}),
    localparam int V_TOTAL = axis_total('{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP}),
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          vs_out,
    output logic          hs_out,
    output logic          de_out,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          frame_start,
    output logic          line_start
);

    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          h_wrap, v_wrap_unused;
    logic          h_active, v_active, h_sync, v_sync;

    timing_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .POL (HS_POL)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (reset),
        .inc    (en),
        .cnt    (h_cnt),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    timing_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .POL (VS_POL)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (reset),
        .inc    (h_wrap),
        .cnt    (v_cnt),
        .wrap   (v_wrap_unused),
        .active (v_active),
        .sync   (v_sync)
    );

    logic          de_q, hs_q, vs_q, fs_q, ls_q;
    logic          de_d, ls_d, fs_d;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    always_comb begin
        de_d = h_active & v_active;
        ls_d = (h_cnt == '0);
        fs_d = ls_d & (v_cnt == '0);
    end

    // v_cnt only moves on the h wrap, so registered vs lands on the x=0 output cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_q <= 1'b0;
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            fs_q <= 1'b0;
            ls_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
        end else if (en) begin
            de_q <= de_d;
            hs_q <= h_sync;
            vs_q <= v_sync;
            fs_q <= fs_d;
            ls_q <= ls_d;
            x_q  <= h_cnt;
            y_q  <= v_cnt;
        end
    end

    assign de_out      = de_q;
    assign hs_out      = hs_q;
    assign vs_out      = vs_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign x           = x_q;
    assign y           = y_q;

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280: active pixels per line.
REQ-002 SHALL have parameter H_FP, default 110: horizontal front porch, in clocks.
REQ-003 SHALL have parameter H_SYNC, default 40: horizontal sync width, in clocks.
REQ-004 SHALL have parameter H_BP, default 220: horizontal back porch, in clocks.
REQ-005 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 720, 5, 5, 20: vertical equivalents, in lines.
REQ-006 SHALL have parameters HS_POL and VS_POL, default 1: asserted sync level (1 = active-high).
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port en, input, 1 bit: timing advance enable.
REQ-010 SHALL have ports vs_out, hs_out, de_out, each output, 1 bit: generated vertical sync, horizontal sync and data enable.
REQ-011 SHALL have port x, output, $clog2(H_TOTAL) bits: current column.
REQ-012 SHALL have port y, output, $clog2(V_TOTAL) bits: current line.
REQ-013 SHALL have ports frame_start and line_start, each output, 1 bit: single-cycle markers.

Function
REQ-014 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; the line order is active, front porch, sync, back porch.
REQ-015 SHALL hold internal counters h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1.
REQ-016 SHALL, on each rising clk edge with en=1, increment h_cnt.
- At h_cnt=H_TOTAL-1, h_cnt SHALL wrap to 0 and v_cnt SHALL increment.
- At v_cnt=V_TOTAL-1 on that same edge, v_cnt SHALL also wrap to 0.
REQ-017 SHALL register all outputs on each rising clk edge with en=1 as a decode of the pre-increment (h_cnt, v_cnt), giving 1 clock latency:
- de_out = (h_cnt < H_ACTIVE) AND (v_cnt < V_ACTIVE).
- hs_out = HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, otherwise ~HS_POL.
- vs_out = VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, otherwise ~VS_POL; it is line-aligned, so it changes only together with h_cnt=0.
- x = h_cnt, y = v_cnt.
- line_start = (h_cnt == 0).
- frame_start = (h_cnt == 0 AND v_cnt == 0).
REQ-018 SHALL, with en=0, hold the counters and all outputs unchanged; a frozen frame_start or line_start is permitted.
REQ-019 SHALL produce de_out, hs_out and vs_out glitch-free, driven directly from flops.
REQ-020 SHALL reject, at elaboration, any timing parameter < 1.

Reset
REQ-021 SHALL, while reset=0 (taking effect immediately, regardless of clk), set h_cnt=0, v_cnt=0, de_out=0, hs_out=~HS_POL, vs_out=~VS_POL, x=0, y=0, frame_start=0 and line_start=0.
REQ-022 SHALL restart from (0,0) on reset asserted mid-frame; the first enabled edge after release SHALL output decode(0,0), i.e. de_out=1 and frame_start=1.

Structure
REQ-023 SHALL place the 720p defaults and a timing-parameter struct type in package video_timing_pkg.
REQ-024 SHALL implement each axis with sub-module timing_axis_counter, instantiated twice.
- Parameters: ACTIVE, FP, SYNC, BP, POL.
- Inputs: inc; outputs: cnt, wrap, active, sync.
- The horizontal wrap SHALL drive the vertical inc.
REQ-025 SHALL compute all widths from the totals with $clog2.

Verification (H 8/2/3/2, H_TOTAL=15; V 4/1/2/1, V_TOTAL=8; both polarities 1)
REQ-026 SHALL cover reset then en=1 -> first edge: de_out=1, x=0, y=0, frame_start=1, line_start=1; frame_start then recurs every 120 clocks.
REQ-027 SHALL cover the active line -> de_out high for exactly 8 consecutive clocks, then low for 7.
- hs_out high for exactly 3 clocks, starting 10 clocks after the de_out rise.
- The pattern repeats every 15 clocks.
REQ-028 SHALL cover the vertical timing -> vs_out high for exactly 30 clocks, rising at x=0, y=5 and falling at x=0, y=7.
- de_out SHALL be 0 throughout lines 4-7.
REQ-029 SHALL cover en=0 held for 5 clocks mid-line (x=3) -> all outputs constant; the next enabled edge gives x=4.
REQ-030 SHALL cover reset pulsed low mid-frame (y=2) without a clk edge -> outputs immediately at reset values (REQ-021); after release the sequence restarts as in REQ-026.
REQ-031 SHALL cover HS_POL=0, VS_POL=0 -> hs_out and vs_out are exact inversions of REQ-027 and REQ-028; de_out is unchanged.
